multu_unit: RTL and testbench
=============================

# multu_unit

Iterative unsigned multiplier with HI/LO result registers for the single-cycle MIPS core. It sits directly downstream of the instruction decoder and executes `multu`, and it serves the register-file write path for `mfhi`/`mflo`. It uses one radix-2 shift-add step per cycle. It raises a stall to the program counter only when a dependent instruction reaches it while a product is still in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits, HI holds the upper half and LO the lower half.

Ports:
- clk, input, 1, core clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high; one clock, synchronous active-high reset.
- start, input, 1, decoder flag: current instruction is `multu` (funct 6'b011001).
- mfhi, input, 1, current instruction is `mfhi` (funct 6'b010000).
- mflo, input, 1, current instruction is `mflo` (funct 6'b010010).
- srca, input, WIDTH, rs operand (multiplicand).
- srcb, input, WIDTH, rt operand (multiplier).
- busy, output, 1, registered; multiplication in progress.
- stall, output, 1, combinational; holds the PC and suppresses the register-file write this cycle.
- hi, output, WIDTH, registered HI.
- lo, output, WIDTH, registered LO.
- hilo_out, output, WIDTH, combinational read data: hi if mfhi, else lo; mfhi wins if both are set.

## Operation
- States: IDLE and RUN.
- Internal registers:
  - acc, WIDTH+1 bits, upper partial product including carry.
  - mplr, WIDTH bits, multiplier, shifts out into the LO side.
  - mcand, WIDTH bits.
  - cnt, counting 0..WIDTH.
- IDLE with start=1, on the edge:
  - mcand <= srca, mplr <= srcb, acc <= 0, cnt <= WIDTH, busy <= 1.
  - Go to RUN.
  - hi/lo are not changed.
- RUN, each edge:
  - sum = acc + (mplr[0] ? mcand : 0), with a WIDTH+1-bit carry.
  - The concatenation {sum, mplr} shifts right by 1: acc gets the upper bits, mplr gets the lower bits.
  - cnt decrements.
- RUN step where cnt==1 (last step):
  - hi <= shifted acc[WIDTH-1:0], lo <= shifted mplr.
  - busy <= 0; return to IDLE.
- start, mfhi and mflo inputs are ignored by the datapath during RUN.
- stall = busy & (start | mfhi | mflo).
  - Independent instructions proceed while the product is in flight.
  - A second `multu` or a HI/LO read waits.
- A held start (stalled `multu`) is accepted on the first edge with busy=0.
- hilo_out is valid whenever stall=0. In the same cycle, the core selects it as the register-file write data for mfhi/mflo.
- Overflow is impossible: the product of two WIDTH-bit unsigned values fits in 2*WIDTH bits. The carry bit acc[WIDTH] is always consumed by the next shift.
- reset (any state, including mid-RUN): state IDLE; busy, hi, lo, acc, mplr, mcand and cnt all 0; the partial product is discarded.

## Timing
- Reset values: busy=0, hi=0, lo=0, hilo_out=0, stall=0 (assuming inputs are low).
- start is sampled at edge E0.
  - busy is high from after E0 through E_WIDTH.
  - hi/lo are updated at E_WIDTH.
  - busy is low after E_WIDTH.
  - Latency is WIDTH cycles after acceptance: 32 by default.
- mflo/mfhi issued one cycle after `multu` (at E1) stalls for WIDTH-1 cycles. It completes in the cycle after E_WIDTH and sees the new value.
- mflo/mfhi in the same cycle as start while IDLE: no stall, and it reads the old hi/lo. The decoder never issues both together, so this case exists only for definition.
- Back-to-back `multu`: the second is accepted at E_WIDTH+1, and its result lands at E_2WIDTH+1.
- Reset asserted concurrently with start: reset wins and nothing is accepted.
- hilo_out and stall are combinational from registered state and the decoder inputs. There is no clock-to-output path through the adder.

## Test plan
- Reset, then start with srca=3, srcb=5: busy is high for exactly 32 cycles; then hi=0x00000000, lo=0x0000000F.
- srca=srcb=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 (checks the carry path). srca=0x80000000, srcb=2: hi=1, lo=0.
- start with 7 and 6, then mflo held from the next cycle: stall=1 for 31 cycles, then stall=0 with hilo_out=42. mfhi in the same window returns 0.
- `multu` issued while busy: stall=1 until busy drops. The second product (0x10000 * 0x10000) is accepted at E33 and lands with hi=1, lo=0. The first result is visible in between.
- reset asserted at RUN cycle 10 of 0x1234*0x5678: the next edge gives busy=0, hi=0, lo=0, stall=0. A fresh 2*2 then yields lo=4.
- An independent instruction (start=mfhi=mflo=0) during RUN: stall stays 0 every cycle, and the final hi/lo are unaffected.

Source files
------------

// File: rtl/multu_unit.sv
// Radix-2 shift-add unsigned multiplier producing HI/LO; WIDTH cycles from acceptance to result.
// Stalls the PC only when multu/mfhi/mflo arrives while a product is still in flight.
module multu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_shift;

  // acc[WIDTH] is always 0 after a shift, so the sum cannot overflow WIDTH+1 bits.
  assign w_addend = r_mplr[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_shift  = {w_sum, r_mplr} >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= srca;
            r_mplr  <= srcb;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc  <= w_shift[2*WIDTH:WIDTH];
          r_mplr <= w_shift[WIDTH-1:0];
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_hi    <= w_shift[2*WIDTH-1:WIDTH];
            r_lo    <= w_shift[WIDTH-1:0];
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall    = r_busy & (start | mfhi | mflo);
  assign hilo_out = mfhi ? r_hi : r_lo;

endmodule

// File: tb/tb_multu_unit.sv
// Randomized and directed checks of multu_unit against a plain-arithmetic product model.
module tb_multu_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mfhi, mflo;
  logic [W-1:0] srca, srcb;
  logic         busy, stall;
  logic [W-1:0] hi, lo, hilo_out;

  int n_pass = 0;
  int n_total = 0;

  multu_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mfhi(mfhi), .mflo(mflo),
    .srca(srca), .srcb(srcb), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Issue one multu, count busy cycles, compare HI/LO with the model.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [2*W-1:0] p;
    int n;
    p = prod(a, b);
    srca = a; srcb = b; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    n_total++;
    if (n !== W) $display("FAIL %s busy_cycles got %0d want %0d", tag, n, W);
    else n_pass++;
    n_total++;
    if ({hi, lo} !== p) $display("FAIL %s hilo got %h_%h want %h", tag, hi, lo, p);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mfhi = 1'b0; mflo = 1'b0; srca = '0; srcb = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    n_total++;
    if ({busy, stall, hi, lo, hilo_out} !== '0)
      $display("FAIL reset_state got busy=%b stall=%b hi=%h lo=%h out=%h want all 0",
               busy, stall, hi, lo, hilo_out);
    else n_pass++;
  endtask

  task automatic test_basic;
    run_mult(32'd3, 32'd5, "mul_3x5");
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    run_mult(32'h8000_0000, 32'd2, "mul_msb");
    run_mult(32'd0, 32'hDEAD_BEEF, "mul_zero");
    for (int i = 0; i < 6; i++) run_mult($urandom, $urandom, "mul_rand");
  endtask

  task automatic test_mflo_stall;
    int n;
    srca = 32'd7; srcb = 32'd6; start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL indep_no_stall got %b want 0", stall);
    else n_pass++;
    tick;
    mflo = 1'b1;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    n_total++;
    if (n !== W - 1) $display("FAIL mflo_stall_cycles got %0d want %0d", n, W - 1);
    else n_pass++;
    n_total++;
    if (hilo_out !== 32'd42) $display("FAIL mflo_read got %h want %h", hilo_out, 32'd42);
    else n_pass++;
    mflo = 1'b0; mfhi = 1'b1;
    #1;
    n_total++;
    if (hilo_out !== 32'd0) $display("FAIL mfhi_read got %h want 0", hilo_out);
    else n_pass++;
    mflo = 1'b1;
    #1;
    n_total++;
    if (hilo_out !== hi || hi !== 32'd0) $display("FAIL mfhi_priority got %h want 0", hilo_out);
    else n_pass++;
    mfhi = 1'b0; mflo = 1'b0;
  endtask

  task automatic test_same_cycle;
    // Idle multu and mflo together: no stall, old LO is returned.
    start = 1'b1; mflo = 1'b1; srca = 32'd9; srcb = 32'd9;
    #1;
    n_total++;
    if (stall !== 1'b0 || hilo_out !== 32'd42)
      $display("FAIL same_cycle got stall=%b out=%h want stall=0 out=%h", stall, hilo_out, 32'd42);
    else n_pass++;
    tick;
    start = 1'b0; mflo = 1'b0;
    for (int i = 0; i < W; i++) tick;
    n_total++;
    if ({hi, lo} !== prod(32'd9, 32'd9) || busy !== 1'b0)
      $display("FAIL same_cycle_result got %h_%h busy=%b want %h", hi, lo, busy, prod(32'd9, 32'd9));
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    srca = 32'd3; srcb = 32'd4; start = 1'b1;
    tick;
    srca = 32'h0001_0000; srcb = 32'h0001_0000;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    n_total++;
    if (n !== W) $display("FAIL b2b_stall_cycles got %0d want %0d", n, W);
    else n_pass++;
    n_total++;
    if ({hi, lo} !== prod(32'd3, 32'd4)) $display("FAIL b2b_first got %h_%h want %h", hi, lo, prod(32'd3, 32'd4));
    else n_pass++;
    tick;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    n_total++;
    if (n !== W || hi !== 32'd1 || lo !== 32'd0)
      $display("FAIL b2b_second got cycles=%0d hi=%h lo=%h want cycles=%0d hi=1 lo=0", n, hi, lo, W);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    srca = 32'h1234; srcb = 32'h5678; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy);
    else n_pass++;
    reset = 1'b1;
    tick;
    reset = 1'b0; mflo = 1'b1;
    #1;
    n_total++;
    if ({busy, stall, hi, lo} !== '0)
      $display("FAIL mid_reset got busy=%b stall=%b hi=%h lo=%h want all 0", busy, stall, hi, lo);
    else n_pass++;
    mflo = 1'b0;
    run_mult(32'd2, 32'd2, "after_reset");
    reset = 1'b1; start = 1'b1;
    tick;
    reset = 1'b0; start = 1'b0;
    tick;
    n_total++;
    if (busy !== 1'b0 || lo !== 32'd0) $display("FAIL reset_vs_start got busy=%b lo=%h want busy=0 lo=0", busy, lo);
    else n_pass++;
  endtask

  task automatic test_independent;
    logic [W-1:0] a, b;
    int bad;
    a = $urandom; b = $urandom;
    srca = a; srcb = b; start = 1'b1;
    tick;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      srca = $urandom; srcb = $urandom;
      #1;
      if (stall !== 1'b0) bad++;
      tick;
    end
    n_total++;
    if (bad !== 0) $display("FAIL indep_stall got %0d stalled cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || {hi, lo} !== prod(a, b))
      $display("FAIL indep_result got busy=%b %h_%h want %h", busy, hi, lo, prod(a, b));
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mflo_stall;
    test_same_cycle;
    test_back_to_back;
    test_reset_mid;
    test_independent;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
